// File: rtl/mat_row_chunker_pkg.sv
// Shared types and default geometry for the row chunker: FSM states, default
// parameter values and the derived chunks-per-segment constant.
package mat_row_chunker_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_ELEM_W    = 32;
    localparam int DEF_ROW_ELEMS = 20;
    localparam int DEF_UNITS     = 8;
    localparam int DEF_ADDR_W    = 17;
    localparam int DEF_CNT_W     = 32;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int MAX_CHUNKS = ceil_div(DEF_ROW_ELEMS, DEF_UNITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } state_t;

endpackage

// File: rtl/mat_row_chunker_chan.sv
// One channel of the chunker: clamped chunk count, chunk index, valid/last
// generation and the chunk mux over the channel's row segment.
module chunk_chan
    import mat_row_chunker_pkg::*;
#(
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int UNITS     = DEF_UNITS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        clear,
    input  logic                        active,
    input  logic [CNT_W-1:0]            num_chunks,
    input  logic [ROW_ELEMS*ELEM_W-1:0] segment,
    input  logic                        ready,
    output logic                        valid,
    output logic                        last,
    output logic                        finishing,
    output logic [UNITS*ELEM_W-1:0]     data
);

    localparam int CHUNKS  = ceil_div(ROW_ELEMS, UNITS);
    localparam int IDX_W   = $clog2(CHUNKS + 1);
    localparam int CHUNK_W = UNITS * ELEM_W;
    localparam int SEG_W   = ROW_ELEMS * ELEM_W;
    localparam int PAD_W   = CHUNKS * CHUNK_W;

    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   cnt_reg;
    logic [PAD_W-1:0]   padded;
    logic [CHUNK_W-1:0] chunk_arr [CHUNKS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
            cnt_reg <= '0;
        end else begin
            if (load) begin
                cnt_reg <= (num_chunks > CNT_W'(CHUNKS)) ? IDX_W'(CHUNKS)
                                                         : num_chunks[IDX_W-1:0];
            end
            if (clear) begin
                idx_reg <= '0;
            end else if (valid && ready) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    // Segment left-aligned so the tail of the last chunk is zero-filled.
    assign padded = PAD_W'(segment) << (PAD_W - SEG_W);

    generate
        for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign chunk_arr[gi] = padded[PAD_W-1-gi*CHUNK_W -: CHUNK_W];
        end
    endgenerate

    always_comb begin
        data = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (idx_reg == IDX_W'(k)) begin
                data = chunk_arr[k];
            end
        end
    end

    assign valid     = active && (idx_reg < cnt_reg);
    assign last      = valid && ((idx_reg + IDX_W'(1)) == cnt_reg);
    // True when this channel has nothing left after the current edge.
    assign finishing = !valid || (last && ready);

endmodule

// File: rtl/mat_row_chunker.sv
// Fetches one memory row on start and streams each channel's segment out as
// fixed-size chunks, all channels concurrently with independent handshakes.
module mat_row_chunker
    import mat_row_chunker_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int UNITS     = DEF_UNITS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  row_addr,
    input  logic [NUM_CH*CNT_W-1:0]            num_chunks,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  mem_rd_addr,
    input  logic [NUM_CH*ROW_ELEMS*ELEM_W-1:0] mem_rd_data,
    output logic [NUM_CH-1:0]                  ch_valid,
    input  logic [NUM_CH-1:0]                  ch_ready,
    output logic [NUM_CH*UNITS*ELEM_W-1:0]     ch_data,
    output logic [NUM_CH-1:0]                  ch_last,
    output logic                               busy,
    output logic                               done
);

    localparam int SEG_W   = ROW_ELEMS * ELEM_W;
    localparam int ROW_W   = NUM_CH * SEG_W;
    localparam int CHUNK_W = UNITS * ELEM_W;

    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [ROW_W-1:0]   row_buf_reg;
    logic               done_reg;
    logic               accept;
    logic               all_fin;
    logic [NUM_CH-1:0]  fin;

    assign accept  = (state_reg == IDLE) && start;
    assign all_fin = &fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = STREAM;
            STREAM:  if (all_fin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (state_reg == FETCH);
        busy      = (state_reg != IDLE);
    end

    // done is registered off the leaving edge so it coincides with busy dropping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg    <= '0;
            row_buf_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg <= row_addr;
            end
            if (state_reg == CAPTURE) begin
                row_buf_reg <= mem_rd_data;
            end
            done_reg <= (state_reg == STREAM) && all_fin;
        end
    end

    assign mem_rd_addr = addr_reg;
    assign done        = done_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            chunk_chan #(
                .ELEM_W    (ELEM_W),
                .ROW_ELEMS (ROW_ELEMS),
                .UNITS     (UNITS),
                .CNT_W     (CNT_W)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .load       (accept),
                .clear      (state_reg == CAPTURE),
                .active     (state_reg == STREAM),
                .num_chunks (num_chunks[(gi+1)*CNT_W-1 -: CNT_W]),
                .segment    (row_buf_reg[(gi+1)*SEG_W-1 -: SEG_W]),
                .ready      (ch_ready[gi]),
                .valid      (ch_valid[gi]),
                .last       (ch_last[gi]),
                .finishing  (fin[gi]),
                .data       (ch_data[(gi+1)*CHUNK_W-1 -: CHUNK_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mat_row_chunker.sv
// Directed bench for mat_row_chunker: a one-cycle-latency memory model and
// per-channel expected chunks built from a known element pattern.
module tb_mat_row_chunker;

    localparam int NUM_CH    = 4;
    localparam int ELEM_W    = 32;
    localparam int ROW_ELEMS = 20;
    localparam int UNITS     = 8;
    localparam int ADDR_W    = 17;
    localparam int CNT_W     = 32;
    localparam int CH_W      = UNITS * ELEM_W;
    localparam int SEG_W     = ROW_ELEMS * ELEM_W;
    localparam int MAXC      = 3;

    logic                               clk = 1'b0;
    logic                               rst = 1'b1;
    logic                               start = 1'b0;
    logic [ADDR_W-1:0]                  row_addr = '0;
    logic [NUM_CH*CNT_W-1:0]            num_chunks = '0;
    logic                               mem_rd_en;
    logic [ADDR_W-1:0]                  mem_rd_addr;
    logic [NUM_CH*SEG_W-1:0]            mem_rd_data = '0;
    logic [NUM_CH-1:0]                  ch_valid;
    logic [NUM_CH-1:0]                  ch_ready = '1;
    logic [NUM_CH*CH_W-1:0]             ch_data;
    logic [NUM_CH-1:0]                  ch_last;
    logic                               busy;
    logic                               done;

    int n_tests = 0;
    int n_fail  = 0;

    mat_row_chunker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .row_addr    (row_addr),
        .num_chunks  (num_chunks),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_data     (ch_data),
        .ch_last     (ch_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [ELEM_W-1:0] elem(input logic [ADDR_W-1:0] a, input int c, input int e);
        return {8'hA5, a[7:0], 8'(c), 8'(e)};
    endfunction

    // Memory: row data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int e = 0; e < ROW_ELEMS; e++) begin
                    mem_rd_data[(c+1)*SEG_W - e*ELEM_W - 1 -: ELEM_W] <= elem(mem_rd_addr, c, e);
                end
            end
        end
    end

    function automatic logic [CH_W-1:0] exp_chunk(input logic [ADDR_W-1:0] a, input int c, input int k);
        logic [CH_W-1:0] r;
        r = '0;
        for (int u = 0; u < UNITS; u++) begin
            if (k*UNITS + u < ROW_ELEMS) begin
                r[(UNITS-u)*ELEM_W-1 -: ELEM_W] = elem(a, c, k*UNITS + u);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode bit0: ch_ready[0] follows 1,0,0 repeating; bit1: re-assert start while busy.
    task automatic run_row(input logic [ADDR_W-1:0] addr, input logic [NUM_CH*CNT_W-1:0] nc,
                           input int mode, input int exp_done_cyc);
        int  eff [NUM_CH];
        int  got [NUM_CH];
        int  cyc;
        bit  finished;
        bit  exp_v;
        logic [CNT_W-1:0] ncc;
        for (int c = 0; c < NUM_CH; c++) begin
            ncc    = nc[(c+1)*CNT_W-1 -: CNT_W];
            eff[c] = (ncc > CNT_W'(MAXC)) ? MAXC : int'(ncc);
            got[c] = 0;
        end
        row_addr   = addr;
        num_chunks = nc;
        ch_ready   = '1;
        start      = 1'b1;
        chk("idle_busy", 256'(busy), 256'(1'b0));
        tick();
        cyc   = 1;
        start = 1'b0;
        if (mode[1]) begin
            start    = 1'b1;
            row_addr = addr + ADDR_W'(7);
        end
        chk("fetch_rd_en", 256'(mem_rd_en), 256'(1'b1));
        chk("fetch_addr", 256'(mem_rd_addr), 256'(addr));
        chk("fetch_busy", 256'(busy), 256'(1'b1));
        chk("fetch_valid", 256'(ch_valid), 256'(0));
        tick();
        cyc   = 2;
        start = 1'b0;
        chk("capture_rd_en", 256'(mem_rd_en), 256'(1'b0));
        chk("capture_valid", 256'(ch_valid), 256'(0));
        finished = 1'b0;
        for (int s = 0; s < 40 && !finished; s++) begin
            tick();
            cyc = 3 + s;
            if (mode[1]) start = (s == 1);
            chk("stream_rd_en", 256'(mem_rd_en), 256'(1'b0));
            chk("stream_done", 256'(done), 256'(1'b0));
            chk("stream_busy", 256'(busy), 256'(1'b1));
            for (int c = 0; c < NUM_CH; c++) begin
                exp_v = (got[c] < eff[c]);
                chk($sformatf("valid_ch%0d", c), 256'(ch_valid[c]), 256'(exp_v));
                chk($sformatf("last_ch%0d", c), 256'(ch_last[c]),
                    256'(exp_v && (got[c] == eff[c] - 1)));
                if (exp_v) begin
                    chk($sformatf("data_ch%0d_k%0d", c, got[c]),
                        256'(ch_data[(c+1)*CH_W-1 -: CH_W]), 256'(exp_chunk(addr, c, got[c])));
                end
            end
            ch_ready = '1;
            if (mode[0]) ch_ready[0] = ((s % 3) == 0);
            finished = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (got[c] < eff[c] && ch_ready[c]) got[c]++;
                if (got[c] < eff[c]) finished = 1'b0;
            end
        end
        if (!finished) chk("stream_timeout", 256'(1'b0), 256'(1'b1));
        start = 1'b0;
        tick();
        cyc++;
        chk("done_pulse", 256'(done), 256'(1'b1));
        chk("done_busy", 256'(busy), 256'(1'b0));
        chk("done_valid", 256'(ch_valid), 256'(0));
        if (exp_done_cyc >= 0) chk("done_cycle", 256'(cyc), 256'(exp_done_cyc));
        tick();
        chk("done_one_cycle", 256'(done), 256'(1'b0));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_rd_en", 256'(mem_rd_en), 256'(1'b0));
        chk("rst_rd_addr", 256'(mem_rd_addr), 256'(0));
        chk("rst_valid", 256'(ch_valid), 256'(0));
        chk("rst_last", 256'(ch_last), 256'(0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_done", 256'(done), 256'(1'b0));
        chk("rst_data", 256'(ch_data === '0), 256'(1'b1));
        rst = 1'b0;
        tick();

        // Full counts, all ready: 3 chunks per channel, done at cycle 6
        run_row(17'd3, {4{32'd3}}, 0, 6);
        // Mixed counts {ch3..ch0} = {0,1,5,2}; ch1 clamps to 3
        run_row(17'd4, {32'd0, 32'd1, 32'd5, 32'd2}, 0, 6);
        // Backpressure on channel 0 only; others finish on schedule
        run_row(17'd6, {4{32'd3}}, 1, 10);
        // Start re-asserted while busy with a different address
        run_row(17'd7, {32'd2, 32'd3, 32'd1, 32'd3}, 2, 6);
        // All counts zero: straight through STREAM with no valid
        run_row(17'd8, {4{32'd0}}, 0, 4);

        // Reset in the middle of streaming after one chunk
        row_addr   = 17'd9;
        num_chunks = {4{32'd3}};
        ch_ready   = '1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_first_valid", 256'(ch_valid), 256'(4'hF));
        chk("mid_first_data", 256'(ch_data[CH_W-1:0]), 256'(exp_chunk(17'd9, 0, 0)));
        tick();
        chk("mid_second_data", 256'(ch_data[CH_W-1:0]), 256'(exp_chunk(17'd9, 0, 1)));
        rst = 1'b1;
        #1;
        chk("abort_valid", 256'(ch_valid), 256'(0));
        chk("abort_last", 256'(ch_last), 256'(0));
        chk("abort_busy", 256'(busy), 256'(1'b0));
        chk("abort_done", 256'(done), 256'(1'b0));
        chk("abort_rd_en", 256'(mem_rd_en), 256'(1'b0));
        chk("abort_rd_addr", 256'(mem_rd_addr), 256'(0));
        chk("abort_data", 256'(ch_data === '0), 256'(1'b1));
        tick();
        rst = 1'b0;
        chk("abort_no_done", 256'(done), 256'(1'b0));
        tick();
        chk("after_abort_done", 256'(done), 256'(1'b0));
        chk("after_abort_busy", 256'(busy), 256'(1'b0));
        run_row(17'd5, {4{32'd3}}, 0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
